// File: rtl/detector_jogada.sv
`default_nettype none
// ============================================================================
// Module   : detector_jogada
// Purpose  : Player-input front end for the game control unit. Synchronizes
//            and debounces the answer buttons. It rejects multi-button
//            presses, and it reports each one-hot press only once until the
//            buttons are fully released. It emits a one-cycle pulse together
//            with a held one-hot code of the accepted button.
// Ports    : clock      - system clock
//            reset      - synchronous, active-high reset
//            botoes     - raw asynchronous buttons, active-high
//            habilita   - press reporting enable (answer-wait window)
//            fez_jogada - one-cycle pulse: a valid press was accepted
//            jogada     - one-hot code of the last reported press (held)
//            db_estado  - debug: current state code (bits [3:2] always 0)
// Revision : 1.0 - initial release
// ============================================================================
module detector_jogada #(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                habilita,
  output logic                fez_jogada,
  output logic [N_BOTOES-1:0] jogada,
  output logic [3:0]          db_estado
);

  localparam int                 c_cnt_w   = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CICLOS - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  typedef enum logic [1:0] {
    AGUARDA_SOLTURA = 2'd0,
    ESPERA          = 2'd1,
    FILTRA_PRESS    = 2'd2,
    PRESSIONADO     = 2'd3
  } estado_t;

  logic [N_BOTOES-1:0] r_sync_0;
  logic [N_BOTOES-1:0] r_sync_1;
  estado_t             r_estado;
  estado_t             w_estado_prox;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_cnt_w-1:0]  w_cnt_prox;
  logic [N_BOTOES-1:0] r_cand;
  logic [N_BOTOES-1:0] w_cand_prox;
  logic                w_aceita;
  logic                w_s_zero;
  logic                w_s_onehot;
  logic [N_BOTOES-1:0] w_s;

  assign w_s        = r_sync_1;
  assign w_s_zero   = (w_s == '0);
  assign w_s_onehot = $onehot(w_s);
  assign db_estado  = {2'b00, r_estado};

  // Next-state logic. The same counter times the release window in
  // AGUARDA_SOLTURA and the press window in FILTRA_PRESS.
  always_comb begin
    w_estado_prox = r_estado;
    w_cnt_prox    = r_cnt;
    w_cand_prox   = r_cand;
    w_aceita      = 1'b0;
    case (r_estado)
      AGUARDA_SOLTURA: begin
        if (!w_s_zero) begin
          w_cnt_prox = '0;
        end else if (r_cnt == c_cnt_max) begin
          w_estado_prox = ESPERA;
        end else begin
          w_cnt_prox = r_cnt + c_cnt_one;
        end
      end
      ESPERA: begin
        if (w_s_onehot) begin
          w_cand_prox   = w_s;
          w_cnt_prox    = '0;
          w_estado_prox = FILTRA_PRESS;
        end else if (!w_s_zero) begin
          // Chord of buttons: ignore it until everything is released.
          w_cnt_prox    = '0;
          w_estado_prox = AGUARDA_SOLTURA;
        end
      end
      FILTRA_PRESS: begin
        if (w_s == r_cand) begin
          if (r_cnt == c_cnt_max) begin
            w_aceita      = 1'b1;
            w_estado_prox = PRESSIONADO;
          end else begin
            w_cnt_prox = r_cnt + c_cnt_one;
          end
        end else if (w_s_zero) begin
          // Bounce back to idle: re-arm immediately, no release window.
          w_estado_prox = ESPERA;
        end else begin
          w_cnt_prox    = '0;
          w_estado_prox = AGUARDA_SOLTURA;
        end
      end
      PRESSIONADO: begin
        // Extra buttons added while held are ignored; only release matters.
        if (w_s_zero) begin
          w_cnt_prox    = '0;
          w_estado_prox = AGUARDA_SOLTURA;
        end
      end
      default: begin
        w_cnt_prox    = '0;
        w_estado_prox = AGUARDA_SOLTURA;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync_0   <= '0;
      r_sync_1   <= '0;
      r_estado   <= AGUARDA_SOLTURA;
      r_cnt      <= '0;
      r_cand     <= '0;
      fez_jogada <= 1'b0;
      jogada     <= '0;
    end else begin
      r_sync_0   <= botoes;
      r_sync_1   <= r_sync_0;
      r_estado   <= w_estado_prox;
      r_cnt      <= w_cnt_prox;
      r_cand     <= w_cand_prox;
      // An accept with reporting disabled still consumes the press.
      fez_jogada <= w_aceita & habilita;
      if (w_aceita && habilita) begin
        jogada <= r_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_detector_jogada.sv
`default_nettype none
// ============================================================================
// Module   : tb_detector_jogada
// Purpose  : Self-checking bench for detector_jogada (N=4, D=4). Stimulus is
//            issued in phases of constant inputs. Before each phase is driven,
//            a run-length reference model predicts the accepted presses and
//            pushes them into a queue. A negedge monitor pops the queue on
//            every fez_jogada pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_detector_jogada;

  localparam int N    = 4;
  localparam int D    = 4;
  localparam int MAXE = 8192;

  // Reference-model modes: waiting for a quiet window, armed, held after
  // an accept, or a short one-hot glitch whose outcome depends on what follows.
  localparam int M_NEED  = 0;
  localparam int M_ARMED = 1;
  localparam int M_HOLD  = 2;
  localparam int M_PEND  = 3;

  logic         clock    = 1'b0;
  logic         reset    = 1'b1;
  logic [N-1:0] botoes   = '0;
  logic         habilita = 1'b1;
  logic         fez_jogada;
  logic [N-1:0] jogada;
  logic [3:0]   db_estado;

  detector_jogada #(.N_BOTOES(N), .DEBOUNCE_CICLOS(D)) dut (
    .clock      (clock),
    .reset      (reset),
    .botoes     (botoes),
    .habilita   (habilita),
    .fez_jogada (fez_jogada),
    .jogada     (jogada),
    .db_estado  (db_estado)
  );

  always #5 clock = ~clock;

  int edge_n = 0;
  always @(posedge clock) edge_n++;

  typedef struct {
    int           e;
    logic [N-1:0] j;
  } exp_t;

  exp_t         exp_q[$];
  logic [N-1:0] tr_b[MAXE];
  logic         tr_h[MAXE];
  logic         tr_r[MAXE];
  int           tests = 0;
  int           fails = 0;
  int           last_pulse_edge = -1;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_n);
    end
  endtask

  // The synchronizer output seen by the detector at edge e.
  function automatic logic [N-1:0] s_at(input int e, input int r);
    if (e - 2 > r) return tr_b[e-2];
    return '0;
  endfunction

  function automatic bit is_onehot(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // Scan the trace since the last reset as runs of equal synchronized values.
  // Push the reported accepts that fall in [lo, hi].
  task automatic predict(input int lo, input int hi);
    int           r;
    int           e;
    int           st;
    int           len;
    int           mode;
    int           z;
    int           acc;
    logic [N-1:0] v;
    exp_t         x;
    r = 0;
    for (int i = hi; i >= 0; i--) begin
      if (tr_r[i]) begin
        r = i;
        break;
      end
    end
    mode = M_NEED;
    z    = D;
    e    = r + 1;
    while (e <= hi) begin
      v  = s_at(e, r);
      st = e;
      while (e <= hi && s_at(e, r) == v) e++;
      len = e - st;
      case (mode)
        M_NEED: begin
          if (v == '0) begin
            if (len >= z) mode = M_ARMED;
          end else begin
            z = D;
          end
        end
        M_HOLD: begin
          if (v == '0) begin
            z    = D + 1;
            mode = (len >= z) ? M_ARMED : M_NEED;
          end
        end
        M_PEND: begin
          if (v == '0) begin
            mode = M_ARMED;
          end else begin
            mode = M_NEED;
            z    = D;
          end
        end
        default: begin
          if (v != '0) begin
            if (!is_onehot(v)) begin
              mode = M_NEED;
              z    = D;
            end else if (len >= D + 1) begin
              acc  = st + D;
              mode = M_HOLD;
              if (acc >= lo && tr_h[acc]) begin
                x.e = acc;
                x.j = v;
                exp_q.push_back(x);
              end
            end else begin
              mode = M_PEND;
            end
          end
        end
      endcase
    end
  endtask

  // Drive constant inputs for n edges; called and returns at a negedge.
  task automatic apply(input logic [N-1:0] b, input logic h, input int n);
    int e0;
    e0 = edge_n + 1;
    if (e0 + n >= MAXE) begin
      $display("FAIL trace_overflow: got %0d edges, limit %0d", e0 + n, MAXE);
      $fatal(1);
    end
    for (int i = 0; i < n; i++) begin
      tr_b[e0+i] = b;
      tr_h[e0+i] = h;
      tr_r[e0+i] = 1'b0;
    end
    predict(e0, e0 + n - 1);
    for (int i = 0; i < n; i++) begin
      reset    = 1'b0;
      botoes   = b;
      habilita = h;
      @(negedge clock);
    end
  endtask

  task automatic do_reset(input logic [N-1:0] b);
    int e0;
    e0 = edge_n + 1;
    tr_b[e0] = b;
    tr_h[e0] = 1'b1;
    tr_r[e0] = 1'b1;
    reset    = 1'b1;
    botoes   = b;
    habilita = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Scoreboard monitor: fez_jogada seen here was produced by edge edge_n.
  always @(negedge clock) begin
    exp_t f;
    while (exp_q.size() > 0 && exp_q[0].e < edge_n) begin
      f = exp_q.pop_front();
      tests++;
      fails++;
      $display("FAIL missed_pulse: got none, expected pulse at edge %0d jogada %b", f.e, f.j);
    end
    if (fez_jogada) begin
      tests++;
      last_pulse_edge = edge_n;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got pulse at edge %0d jogada %b, expected none", edge_n, jogada);
      end else begin
        f = exp_q.pop_front();
        if (f.e != edge_n || f.j != jogada) begin
          fails++;
          $display("FAIL pulse: got edge %0d jogada %b, expected edge %0d jogada %b",
                   edge_n, jogada, f.e, f.j);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int           ps;
    int           k;
    logic [N-1:0] v;
    logic         h;
    @(negedge clock);
    tr_r[1] = 1'b1;
    tr_b[1] = '0;
    tr_h[1] = 1'b1;

    do_reset('0);
    check("reset_fez", fez_jogada, 0);
    check("reset_jogada", jogada, 0);
    check("reset_estado", db_estado, 0);

    apply(4'b0000, 1'b1, 10);
    check("idle_espera", db_estado, 1);

    ps = edge_n + 1;
    apply(4'b0010, 1'b1, 12);
    check("press_latency", last_pulse_edge, ps + 2 + D);
    check("press_jogada", jogada, 4'b0010);
    check("press_estado", db_estado, 3);
    apply(4'b0000, 1'b1, 8);
    check("release_espera", db_estado, 1);

    // Bounce shorter than the debounce window.
    apply(4'b0001, 1'b1, 2);
    apply(4'b0000, 1'b1, 1);
    apply(4'b0001, 1'b1, 2);
    apply(4'b0000, 1'b1, 8);
    check("bounce_estado", db_estado, 1);
    check("bounce_jogada", jogada, 4'b0010);

    // Chord of two buttons.
    apply(4'b0101, 1'b1, 3);
    check("multi_estado", db_estado, 0);
    apply(4'b0101, 1'b1, 17);
    apply(4'b0000, 1'b1, 6);
    check("multi_release", db_estado, 1);

    // Accept while reporting disabled, then enable while still held.
    apply(4'b0100, 1'b0, 10);
    check("hab0_jogada", jogada, 4'b0010);
    check("hab0_estado", db_estado, 3);
    apply(4'b0100, 1'b1, 10);
    check("hab1_held_jogada", jogada, 4'b0010);
    apply(4'b0000, 1'b1, 8);

    // Long hold, short release, re-press, then a proper release.
    apply(4'b1000, 1'b1, 50);
    apply(4'b0000, 1'b1, 3);
    apply(4'b1000, 1'b1, 20);
    apply(4'b0000, 1'b1, 8);
    apply(4'b1000, 1'b1, 12);
    check("repress_jogada", jogada, 4'b1000);
    apply(4'b0000, 1'b1, 8);

    // Reset in the middle of press filtering.
    apply(4'b0001, 1'b1, 5);
    check("filtra_estado", db_estado, 2);
    do_reset(4'b0001);
    check("midreset_fez", fez_jogada, 0);
    check("midreset_jogada", jogada, 0);
    check("midreset_estado", db_estado, 0);
    apply(4'b0001, 1'b1, 20);
    check("held_after_reset", db_estado, 0);
    apply(4'b0000, 1'b1, 8);
    apply(4'b0001, 1'b1, 10);
    check("after_reset_jogada", jogada, 4'b0001);

    // Randomized phases.
    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 99);
      if (k < 3) begin
        v = 4'($urandom_range(0, 15));
        do_reset(v);
      end else begin
        if (k < 60)      v = 4'b0001 << $urandom_range(0, 3);
        else if (k < 85) v = 4'b0000;
        else             v = 4'($urandom_range(0, 15));
        h = ($urandom_range(0, 9) != 0);
        apply(v, h, (v == '0) ? $urandom_range(1, 12) : $urandom_range(1, 9));
      end
    end

    apply(4'b0000, 1'b1, 20);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
